// File: rtl/seq_arith_8b_sminmax_if.sv
// ---------------------------------------------------------------------------
// seq_arith_8b_sminmax_if
//
// Purpose: bundles the element input stream and the result output stream of
// the streaming min/max reducer into a single interface.
//
// Signals:
//   in_val    element valid (producer -> reducer)
//   in_rdy    reducer can accept an element (reducer -> producer)
//   in_data   8-bit element
//   in_last   final element of the packet, qualified by accept
//   out_val   result valid (reducer -> consumer)
//   out_rdy   consumer takes the result (consumer -> reducer)
//   out_min   packet minimum
//   out_max   packet maximum
//   out_count element count, saturating at 255
//   out_eq    all elements of the packet were equal
//
// Modports:
//   slave  - the reducer itself
//   master - the environment driving elements and collecting results
// ---------------------------------------------------------------------------
interface seq_arith_8b_sminmax_if;

    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_min;
    logic [7:0] out_max;
    logic [7:0] out_count;
    logic       out_eq;

    modport slave (
        input  in_val,
        input  in_data,
        input  in_last,
        input  out_rdy,
        output in_rdy,
        output out_val,
        output out_min,
        output out_max,
        output out_count,
        output out_eq
    );

    modport master (
        output in_val,
        output in_data,
        output in_last,
        output out_rdy,
        input  in_rdy,
        input  out_val,
        input  out_min,
        input  out_max,
        input  out_count,
        input  out_eq
    );

endinterface

// File: rtl/seq_arith_8b_sminmax.sv
// ---------------------------------------------------------------------------
// seq_arith_8b_sminmax
//
// Purpose: streaming min/max reducer for 8-bit operands. Elements of a packet
// arrive on a valid/ready stream; when the element tagged in_last has been
// taken, the running minimum, running maximum, element count (saturating at
// 255) and an all-equal flag are offered on a valid/ready result stream.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    seq_arith_8b_sminmax_if.slave carrying both streams
//
// Build option:
//   SEQ_ARITH_8B_SMINMAX_UNSIGNED_EN  when defined, comparisons treat the
//   operands as unsigned 0..255; otherwise they are two's-complement signed.
// ---------------------------------------------------------------------------
module seq_arith_8b_sminmax (
    input  logic                         clk,
    input  logic                         reset,
    seq_arith_8b_sminmax_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_FIRST,
        ST_ACCUM,
        ST_OUT
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic [7:0] min_q;
    logic [7:0] max_q;
    logic [7:0] count_q;

    logic       in_rdy_c;
    logic       out_val_c;
    logic       accept;
    logic       handoff;
    logic       is_less;
    logic       is_greater;

    // The comparators are the only thing the build option changes; everything
    // downstream just consumes the less-than / greater-than decisions.
`ifdef SEQ_ARITH_8B_SMINMAX_UNSIGNED_EN
    assign is_less    = (bus.in_data < min_q);
    assign is_greater = (bus.in_data > max_q);
`else
    assign is_less    = ($signed(bus.in_data) < $signed(min_q));
    assign is_greater = ($signed(bus.in_data) > $signed(max_q));
`endif

    assign accept  = bus.in_val  && in_rdy_c;
    assign handoff = out_val_c   && bus.out_rdy;

    // State register. Reset drops any partial packet by returning to FIRST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs. in_rdy and out_val depend on state
    // alone so there is no combinational path from in_val or out_rdy back to
    // the handshake outputs; the result and the next packet therefore never
    // overlap in the same cycle.
    always_comb begin
        state_d   = state_q;
        in_rdy_c  = 1'b0;
        out_val_c = 1'b0;
        case (state_q)
            ST_FIRST: begin
                in_rdy_c = 1'b1;
                if (bus.in_val) begin
                    state_d = bus.in_last ? ST_OUT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_rdy_c = 1'b1;
                if (bus.in_val && bus.in_last) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                out_val_c = 1'b1;
                if (bus.out_rdy) begin
                    state_d = ST_FIRST;
                end
            end
            default: begin
                state_d = ST_FIRST;
            end
        endcase
    end

    // Datapath registers. The first element of a packet seeds min/max and the
    // count; later elements only replace min/max on a strict win, so ties
    // leave the registers alone. The count sticks at 255 instead of wrapping.
    // Outside an accept the registers hold, which keeps the last result
    // visible through OUT and on into FIRST until the next packet starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_q   <= 8'h00;
            max_q   <= 8'h00;
            count_q <= 8'h00;
        end else if (accept) begin
            if (state_q == ST_FIRST) begin
                min_q   <= bus.in_data;
                max_q   <= bus.in_data;
                count_q <= 8'd1;
            end else begin
                if (is_less) begin
                    min_q <= bus.in_data;
                end
                if (is_greater) begin
                    max_q <= bus.in_data;
                end
                if (count_q != 8'hFF) begin
                    count_q <= count_q + 8'd1;
                end
            end
        end
    end

    assign bus.in_rdy    = in_rdy_c;
    assign bus.out_val   = out_val_c;
    assign bus.out_min   = min_q;
    assign bus.out_max   = max_q;
    assign bus.out_count = count_q;
    // Equal extremes can only happen when every element matched the first.
    assign bus.out_eq    = (min_q == max_q);

    // The handoff strobe is folded into the FSM above; it is kept as a named
    // signal so the result transfer condition is visible in one place.
    logic handoff_unused;
    assign handoff_unused = handoff;

endmodule

// File: tb/tb_seq_arith_8b_sminmax.sv
// ---------------------------------------------------------------------------
// tb_seq_arith_8b_sminmax
//
// Purpose: self-checking bench for seq_arith_8b_sminmax. Directed packets and
// randomly generated packets are pushed through the reducer; the expected
// min/max/count/all-equal values come from a plain reference model that walks
// the packet contents held in a queue.
//
// Build option: SEQ_ARITH_8B_SMINMAX_UNSIGNED_EN switches the reference model
// to unsigned ordering to match the design build.
// ---------------------------------------------------------------------------
module tb_seq_arith_8b_sminmax;

    logic clk;
    logic reset;

    int vectors;
    int miscompares;

    logic [7:0] pkt[$];

    seq_arith_8b_sminmax_if bus ();

    seq_arith_8b_sminmax dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison point: counts the vector and reports any difference.
    task automatic compareValue(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    // Ordering key for an element: signed value by default, raw value when
    // the design is built for unsigned comparison.
    function automatic int keyOf(input logic [7:0] v);
`ifdef SEQ_ARITH_8B_SMINMAX_UNSIGNED_EN
        return int'(v);
`else
        return int'($signed(v));
`endif
    endfunction

    // Reference model: the extreme elements of the packet, its size clipped
    // to 255, and whether the extremes coincide.
    task automatic computeExpected(output logic [7:0] emin, output logic [7:0] emax,
                                   output logic [7:0] ecount, output logic eeq);
        emin = pkt[0];
        emax = pkt[0];
        foreach (pkt[i]) begin
            if (keyOf(pkt[i]) < keyOf(emin)) emin = pkt[i];
            if (keyOf(pkt[i]) > keyOf(emax)) emax = pkt[i];
        end
        ecount = (pkt.size() > 255) ? 8'd255 : 8'(pkt.size());
        eeq    = (emin == emax);
    endtask

    // Streams the queued packet, one element per cycle, starting and ending on
    // a falling edge. withLast=0 leaves the packet open (used for aborts).
    task automatic applyStimulus(input bit withLast);
        foreach (pkt[i]) begin
            bus.in_val  = 1'b1;
            bus.in_data = pkt[i];
            bus.in_last = withLast && (i == pkt.size() - 1);
            if (i == 0 || i == pkt.size() - 1) begin
                compareValue("in_rdy_while_streaming", {7'd0, bus.in_rdy}, 8'd1);
            end
            @(negedge clk);
        end
        bus.in_val  = 1'b0;
        bus.in_last = 1'b0;
    endtask

    // Called on the falling edge right after the last element was taken.
    // Checks the result for stallCycles+1 cycles of OUT while out_rdy is low
    // and junk elements are offered, then completes the handoff and checks
    // the return to FIRST with the result still held.
    task automatic checkOutput(input string tag, input int stallCycles);
        logic [7:0] emin, emax, ecount;
        logic       eeq;
        computeExpected(emin, emax, ecount, eeq);
        for (int c = 0; c <= stallCycles; c++) begin
            compareValue({tag, "_out_val"}, {7'd0, bus.out_val}, 8'd1);
            compareValue({tag, "_in_rdy"},  {7'd0, bus.in_rdy},  8'd0);
            compareValue({tag, "_min"},     bus.out_min,         emin);
            compareValue({tag, "_max"},     bus.out_max,         emax);
            compareValue({tag, "_count"},   bus.out_count,       ecount);
            compareValue({tag, "_eq"},      {7'd0, bus.out_eq},  {7'd0, eeq});
            if (c < stallCycles) begin
                bus.out_rdy = 1'b0;
                bus.in_val  = 1'b1;
                bus.in_data = 8'($urandom);
                bus.in_last = 1'($urandom);
            end else begin
                bus.out_rdy = 1'b1;
                bus.in_val  = 1'b0;
                bus.in_last = 1'b0;
            end
            @(negedge clk);
        end
        bus.out_rdy = 1'b0;
        compareValue({tag, "_after_out_val"}, {7'd0, bus.out_val}, 8'd0);
        compareValue({tag, "_after_in_rdy"},  {7'd0, bus.in_rdy},  8'd1);
        compareValue({tag, "_after_min"},     bus.out_min,         emin);
        compareValue({tag, "_after_count"},   bus.out_count,       ecount);
    endtask

    // Directed scenarios first, then random packets with random backpressure.
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.in_val  = 1'b0;
        bus.in_data = 8'h00;
        bus.in_last = 1'b0;
        bus.out_rdy = 1'b0;

        repeat (2) @(negedge clk);
        compareValue("reset_in_rdy",  {7'd0, bus.in_rdy},  8'd1);
        compareValue("reset_out_val", {7'd0, bus.out_val}, 8'd0);
        compareValue("reset_min",     bus.out_min,         8'h00);
        compareValue("reset_max",     bus.out_max,         8'h00);
        compareValue("reset_count",   bus.out_count,       8'h00);
        compareValue("reset_eq",      {7'd0, bus.out_eq},  8'd1);
        reset = 1'b0;
        @(negedge clk);

        pkt = '{8'h05, 8'hFD, 8'h7F, 8'h80};
        applyStimulus(1'b1);
        checkOutput("mixed4", 0);

        pkt = '{8'hC0};
        applyStimulus(1'b1);
        checkOutput("single", 0);

        pkt = '{8'h01, 8'h02};
        applyStimulus(1'b1);
        checkOutput("backtoback", 3);

        pkt = {};
        for (int i = 0; i < 300; i++) pkt.push_back(8'h00);
        applyStimulus(1'b1);
        checkOutput("saturate", 0);

        pkt = '{8'h10, 8'hF0};
        applyStimulus(1'b0);
        reset = 1'b1;
        #1;
        compareValue("abort_out_val", {7'd0, bus.out_val}, 8'd0);
        compareValue("abort_count",   bus.out_count,       8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        compareValue("abort_idle_out_val", {7'd0, bus.out_val}, 8'd0);
        compareValue("abort_idle_in_rdy",  {7'd0, bus.in_rdy},  8'd1);
        pkt = '{8'h03};
        applyStimulus(1'b1);
        checkOutput("after_abort", 0);

        pkt = '{8'h80, 8'h01};
        applyStimulus(1'b1);
        checkOutput("order", 1);

        for (int p = 0; p < 25; p++) begin
            int len;
            len = int'($urandom_range(1, 20));
            pkt = {};
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) pkt.push_back(8'h80);
                else pkt.push_back(8'($urandom));
            end
            applyStimulus(1'b1);
            checkOutput("random", int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_arith_8b_sminmax.md
# seq_arith_8b_sminmax

Streaming signed min/max reducer for 8-bit two's-complement operands. It accepts a packet of values over a valid/ready input stream and applies the same signed less-than/greater-than decisions used by the combinational comparators in the arithmetic datapath. When the packet ends it returns the running minimum, the running maximum, an element count and an all-equal flag over a valid/ready output stream. It sits downstream of sample producers and upstream of range/normalisation logic.

## Interface
- Parameters: none; operand width is fixed at 8 bits.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  1  input element valid.
- in_rdy  output  1  block can accept an element.
- in_data  input  8  element, two's-complement signed.
- in_last  input  1  marks the final element of a packet; sampled only on accept.
- out_val  output  1  result valid.
- out_rdy  input  1  consumer accepts the result.
- out_min  output  8  minimum of the packet, signed.
- out_max  output  8  maximum of the packet, signed.
- out_count  output  8  number of elements in the packet, saturating at 255.
- out_eq  output  1  1 when out_min == out_max, meaning all elements are equal.

## Operation
- Accept: in_val && in_rdy. Result handoff: out_val && out_rdy.
- The FSM has three states: FIRST, ACCUM and OUT. Reset state is FIRST.
- FIRST:
  - in_rdy=1, out_val=0.
  - On accept: min=max=in_data and count=1.
  - Next state is OUT if in_last, else ACCUM.
- ACCUM:
  - in_rdy=1, out_val=0.
  - On accept: if $signed(in_data) < $signed(min), min=in_data. If $signed(in_data) > $signed(max), max=in_data. count=count+1, saturating at 255 (no wrap).
  - Next state is OUT if in_last.
- OUT:
  - in_rdy=0, out_val=1. Outputs are held stable.
  - On handoff, go to FIRST.
  - in_val is ignored in this state.
- out_eq is combinational from the min/max registers and is meaningful only while out_val=1.
- Packets contain at least one element; an empty packet cannot be expressed.
- Ties (in_data equal to the current min or max) leave the registers unchanged.

## Timing
- Reset values: in_rdy=1, out_val=0, out_min=0x00, out_max=0x00, out_count=0x00, out_eq=1.
- One element is accepted per cycle in FIRST and ACCUM. There are no bubbles between packets other than the OUT handoff.
- Latency: out_val rises on the cycle after the in_last element is accepted.
- out_val stays high until out_rdy is sampled high. The minimum OUT dwell is 1 cycle.
- in_rdy is 0 for every cycle spent in OUT. After the handoff, in_rdy returns to 1 on the next cycle; there is no same-cycle result/accept overlap.
- in_rdy and out_val are functions of state only, with no combinational path from in_val or out_rdy.
- Reset asserted at any point, including mid-packet or in OUT, immediately returns all state to reset values. The partial packet is discarded and no result is produced for it.
- The min/max/count registers retain the last result while in FIRST. They are overwritten by the first accept of the next packet.

## Configuration
- SEQ_ARITH_8B_SMINMAX_UNSIGNED_EN:
  - Defined: both comparisons are unsigned, so in_data, out_min and out_max are interpreted as 0..255.
  - Undefined (default): comparisons are signed two's-complement, −128..127.
  - All other behaviour is identical in both builds.

## Test plan
- Reset then packet {0x05, 0xFD(−3), 0x7F, 0x80(−128, last)}, out_rdy=1 -> one cycle after the last accept: out_val=1, out_min=0x80, out_max=0x7F, out_count=4, out_eq=0.
- Single-element packet 0xC0 with in_last=1 -> out_min=out_max=0xC0, out_count=1, out_eq=1. Back-to-back packet {0x01, 0x02(last)} -> out_min=0x01, out_max=0x02, in_rdy=1 the cycle after the first handoff.
- Backpressure: hold out_rdy=0 for 3 cycles in OUT -> out_val and outputs stable, in_rdy=0, and in_val pulses ignored. out_rdy=1 -> FIRST next cycle.
- 300-element packet of 0x00 -> out_count=255 (saturated), out_min=out_max=0x00, out_eq=1.
- Assert reset for 1 cycle after 2 elements {0x10, 0xF0}, then send {0x03(last)} -> out_min=out_max=0x03, out_count=1, with no result emitted for the aborted packet.
- Packet {0x80, 0x01(last)}: default build -> out_min=0x80, out_max=0x01. With SEQ_ARITH_8B_SMINMAX_UNSIGNED_EN -> out_min=0x01, out_max=0x80.
